sprinkler_zone_sequencer: RTL
=============================

// Module: sprinkler_zone_sequencer
// PURPOSE
//  Sequences the 4-zone sprinkler valve datapath. Drives the 4:1 select mux
//  (s0,s1) and the master valve enable. On start it waters each enabled zone
//  in ascending order, for a fixed time per zone.
//  Break-before-make: the valve is closed while the select lines change.
//  Sits between the front-panel controls (start/abort/zone switches) and the mux.
// PARAMETERS
//  TICK_DIV       4   clocks per watering tick (prescaler divide ratio, >=1)
//  RUN_TICKS      5   ticks each enabled zone stays open (>=1)
//  SETTLE_CYCLES  2   clocks valve held closed after select change (>=1)
// PORTS
//  clk        in   1  system clock, rising edge
//  rst        in   1  asynchronous, active-high reset
//  start      in   1  level sampled each clk; starts a cycle when IDLE
//  abort      in   1  stops watering; priority over everything except rst
//  zone_en    in   4  zone enable switches, bit z = zone z
//  s0         out  1  mux select MSB (zone index bit 1)
//  s1         out  1  mux select LSB (zone index bit 0)
//  valve_on   out  1  master valve enable
//  zone_act   out  4  one-hot active zone, valid only while valve_on=1, else 0
//  busy       out  1  high in every state except IDLE
//  done       out  1  one-clock pulse when a full cycle completes
// BEHAVIOUR
//  - Decided: one clock; reset is asynchronous and active-high (clk, rst).
//  - Reset (async, no clock needed): state=IDLE, s0=s1=0, valve_on=0,
//    zone_act=0, busy=0, done=0, counters=0. Deasserting rst starts nothing.
//  - Select mapping: zone z -> {s0,s1}=z, i.e. 00->i0, 01->i1, 10->i2, 11->i3.
//  - States: IDLE, SETTLE, RUN, DONE. All outputs are registered.
//  - IDLE: start=1 && zone_en!=0 -> latch zone_en into en_q; zone = lowest
//    set bit; go to SETTLE. start with zone_en==0 is ignored (stays IDLE).
//  - SETTLE: select drives zone, valve_on=0, for exactly SETTLE_CYCLES clocks,
//    then RUN.
//  - RUN: valve_on=1 and zone_act=1<<zone. Prescaler restarts on RUN entry.
//    RUN lasts exactly RUN_TICKS*TICK_DIV clocks. Then: next higher set bit
//    of en_q -> SETTLE with that zone; none left -> DONE.
//  - DONE: exactly 1 clock: done=1, valve_on=0, busy=1; then IDLE.
//  - IDLE/DONE drive s0=s1=0.
//  - Per-zone cost: SETTLE_CYCLES + RUN_TICKS*TICK_DIV clocks (defaults: 22).
//  - abort=1 in any non-IDLE state: next edge -> IDLE with all outputs at
//    reset values; done is NOT pulsed. abort in IDLE has no effect.
//  - start while busy: ignored. zone_en changes after start: ignored (en_q).
//  - Simultaneous start+abort in IDLE: abort wins, stays IDLE.
//  - Wrap-around: zones never revisit; zone 3 is always last; no wrap to 0.
//  - Counters are sized $clog2 of their max count; they never overflow.
// STRUCTURE
//  - Shared include sprinkler_defs.vh: state encodings, NUM_ZONES=4,
//    ZONE_W=2.
//  - Sub-module tick_prescaler (clk, rst, clr, tick): mod-TICK_DIV counter
//    with a 1-clock tick output. clr is asserted on RUN entry.
//  - Top holds the FSM, settle counter, tick counter, en_q and zone
//    registers, and a priority "next enabled zone above z" function.
// TESTING (defaults; cycle 0 = first SETTLE clock after start is sampled)
//  1. zone_en=1111, start pulse -> {s0,s1}=00,01,10,11 in order.
//     Each zone: valve_on 0 for 2 clocks, then 1 for 20 clocks.
//     done=1 only in cycle 88; busy=0 from cycle 89.
//  2. zone_en=1010 -> only zones 1 then 3 (zone_act 0010, 1000);
//     zones 0 and 2 never selected; done in cycle 44.
//  3. zone_en=0000, start=1 for 3 clocks -> busy, valve_on, done stay 0.
//  4. zone_en=1111, abort at cycle 50 (zone 2 RUN) -> next edge:
//     valve_on=0, {s0,s1}=00, busy=0; no done pulse.
//  5. rst asserted mid-RUN between edges -> valve_on/busy fall without a
//     clock edge; after release the block stays IDLE until a new start.
//  6. During a run: start re-pulsed and zone_en changed 1111->0001 ->
//     sequence and done timing identical to test 1.

Source files
------------

// File: rtl/sprinkler_zone_sequencer_pkg.sv
// Shared types and helpers for the sprinkler zone sequencer.
// Holds state encodings, zone sizing and the "next enabled zone" search.
package sprinkler_zone_sequencer_pkg;

   localparam int NUM_ZONES = 4;
   localparam int ZONE_W    = 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RUN    = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Returns {found, zone}: the lowest set bit of en at index >= from.
   function automatic logic [ZONE_W:0] next_zone(input logic [NUM_ZONES-1:0] en,
                                                 input int from);
      logic [ZONE_W:0] res;
      res = '0;
      for (int i = NUM_ZONES - 1; i >= 0; i--) begin
         if (i >= from && en[i]) begin
            res = {1'b1, ZONE_W'(i)};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/sprinkler_zone_sequencer_tick_prescaler.sv
// Mod-TICK_DIV counter producing a one-clock tick; clr restarts the count at 0.
// Tick is decoded from the count register, no input backpressure.
module tick_prescaler #(
   parameter int TICK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/sprinkler_zone_sequencer.sv
// Sequences enabled sprinkler zones in ascending order with break-before-make.
// Outputs registered (decoded from next state); abort returns to IDLE on the next edge.
module sprinkler_zone_sequencer
   import sprinkler_zone_sequencer_pkg::*;
#(
   parameter int TICK_DIV      = 4,
   parameter int RUN_TICKS     = 5,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic [3:0] zone_en,
   output logic       s0,
   output logic       s1,
   output logic       valve_on,
   output logic [3:0] zone_act,
   output logic       busy,
   output logic       done
);

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int TW = (RUN_TICKS > 1) ? $clog2(RUN_TICKS) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0] TICK_LAST   = TW'(RUN_TICKS - 1);

   state_t              state, state_nxt;
   logic [ZONE_W-1:0]   zone, zone_nxt;
   logic [3:0]          en_q, en_q_nxt;
   logic [SW-1:0]       settle_cnt, settle_nxt;
   logic [TW-1:0]       tick_cnt, tick_nxt;
   logic [ZONE_W:0]     first_z, after_z;
   logic                tick, run_entry;
   logic                s0_nxt, s1_nxt, valve_nxt, busy_nxt, done_nxt;
   logic [3:0]          act_nxt;

   assign first_z = next_zone(zone_en, 0);
   assign after_z = next_zone(en_q, int'(zone) + 1);

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .clr  (run_entry),
      .tick (tick)
   );

   always_comb begin
      state_nxt  = state;
      zone_nxt   = zone;
      en_q_nxt   = en_q;
      settle_nxt = settle_cnt;
      tick_nxt   = tick_cnt;

      case (state)
         ST_IDLE: begin
            if (start && !abort && zone_en != 4'b0000) begin
               en_q_nxt   = zone_en;
               zone_nxt   = first_z[ZONE_W-1:0];
               settle_nxt = '0;
               state_nxt  = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
               tick_nxt  = '0;
               state_nxt = ST_RUN;
            end else begin
               settle_nxt = settle_cnt + 1'b1;
            end
         end
         ST_RUN: begin
            if (tick) begin
               if (tick_cnt == TICK_LAST) begin
                  if (after_z[ZONE_W]) begin
                     zone_nxt   = after_z[ZONE_W-1:0];
                     settle_nxt = '0;
                     state_nxt  = ST_SETTLE;
                  end else begin
                     state_nxt = ST_DONE;
                  end
               end else begin
                  tick_nxt = tick_cnt + 1'b1;
               end
            end
         end
         ST_DONE: begin
            zone_nxt  = '0;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase

      // Abort overrides every transition out of a busy state.
      if (abort && state != ST_IDLE) begin
         state_nxt  = ST_IDLE;
         zone_nxt   = '0;
         en_q_nxt   = '0;
         settle_nxt = '0;
         tick_nxt   = '0;
      end

      run_entry = (state != ST_RUN) && (state_nxt == ST_RUN);

      s0_nxt    = 1'b0;
      s1_nxt    = 1'b0;
      if (state_nxt == ST_SETTLE || state_nxt == ST_RUN) begin
         s0_nxt = zone_nxt[1];
         s1_nxt = zone_nxt[0];
      end
      valve_nxt = (state_nxt == ST_RUN);
      act_nxt   = valve_nxt ? (4'b0001 << zone_nxt) : 4'b0000;
      busy_nxt  = (state_nxt != ST_IDLE);
      done_nxt  = (state_nxt == ST_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         zone       <= '0;
         en_q       <= '0;
         settle_cnt <= '0;
         tick_cnt   <= '0;
         s0         <= 1'b0;
         s1         <= 1'b0;
         valve_on   <= 1'b0;
         zone_act   <= 4'b0000;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nxt;
         zone       <= zone_nxt;
         en_q       <= en_q_nxt;
         settle_cnt <= settle_nxt;
         tick_cnt   <= tick_nxt;
         s0         <= s0_nxt;
         s1         <= s1_nxt;
         valve_on   <= valve_nxt;
         zone_act   <= act_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
      end
   end

endmodule
